// File: rtl/key_freq_ctrl.sv
// key_freq_ctrl: debounced key front-end for the flowing-water LED display.
// The start key yields a one-cycle `button` pulse per accepted press.
// The mode key advances the 2-bit `freq_set` period selector, wrapping 11 -> 00.
// Each key has its own two-flop synchronizer, debounce FSM and counter.
module key_freq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_mode,
    output logic       button,
    output logic [1:0] freq_set
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } db_state_t;

    // Channel index: bit 0 = start key, bit 1 = mode key.
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    db_state_t     state [2];
    logic [CW-1:0] cnt   [2];
    logic [1:0]    press_evt;

    // Two-flop synchronizers for both raw keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {key_mode, key_start};
            sync_b <= sync_a;
        end
    end

    // Press event: last stable-high sample of a press debounce.
    always_comb begin
        press_evt = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            press_evt[i] = (state[i] == PRESS_DB) && sync_b[i] && (cnt[i] == LAST);
        end
    end

    // Debounce FSMs for both channels plus the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            button   <= 1'b0;
            freq_set <= 2'b11;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                case (state[i])
                    IDLE: begin
                        cnt[i] <= '0;
                        if (sync_b[i]) begin
                            state[i] <= PRESS_DB;
                        end
                    end
                    PRESS_DB: begin
                        if (!sync_b[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == LAST) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        cnt[i] <= '0;
                        if (!sync_b[i]) begin
                            state[i] <= RELEASE_DB;
                        end
                    end
                    RELEASE_DB: begin
                        if (sync_b[i]) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == LAST) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
            button   <= press_evt[0];
            freq_set <= freq_set + {1'b0, press_evt[1]};
        end
    end

endmodule

// File: tb/tb_key_freq_ctrl.sv
// Self-checking bench for key_freq_ctrl with DEBOUNCE_CYCLES = 8.
// Reference model: a key level is accepted once the synchronized key (raw key
// delayed two edges) has differed from the accepted level for DB+1 edges in a row.
module tb_key_freq_ctrl;

    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start;
    logic       key_mode;
    logic       button;
    logic [1:0] freq_set;

    always #5 clk = ~clk;

    key_freq_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_start(key_start),
        .key_mode (key_mode),
        .button   (button),
        .freq_set (freq_set)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit check_en = 1'b0;

    // Model state, index 0 = start, 1 = mode
    int         acc [2];
    int         run_len [2];
    bit         k1 [2];
    bit         k2 [2];
    logic       exp_button;
    logic [1:0] exp_freq;

    // Observation of DUT activity for the hand-computed checks
    int         pulses;
    int         pulse_cyc;
    int         freq_cyc;
    logic [1:0] last_freq;
    logic [1:0] freq_hist [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            acc[c]     = 0;
            run_len[c] = 0;
            k1[c]      = 1'b0;
            k2[c]      = 1'b0;
        end
        exp_button = 1'b0;
        exp_freq   = 2'b11;
    endtask

    task automatic model_edge();
        bit keys [2];
        bit ev [2];
        bit s;
        if (!rst_n) return;
        keys[0] = key_start;
        keys[1] = key_mode;
        for (int c = 0; c < 2; c++) begin
            ev[c] = 1'b0;
            s     = k2[c];
            k2[c] = k1[c];
            k1[c] = keys[c];
            if (int'(s) != acc[c]) begin
                run_len[c]++;
                if (run_len[c] == DB + 1) begin
                    acc[c]     = int'(s);
                    run_len[c] = 0;
                    ev[c]      = s;
                end
            end else begin
                run_len[c] = 0;
            end
        end
        exp_button = ev[0];
        if (ev[1]) exp_freq = 2'((int'(exp_freq) + 1) % 4);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (button === 1'b1) begin
                pulses++;
                pulse_cyc = cyc;
            end
            if (freq_set !== last_freq) begin
                freq_hist.push_back(freq_set);
                freq_cyc  = cyc;
                last_freq = freq_set;
            end
        end
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_button", button, 0);
        check("async_reset_freq", freq_set, 3);
    endtask

    task automatic release_reset();
        step();
        step();
        rst_n     = 1'b1;
        last_freq = 2'b11;
        freq_hist.delete();
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("button", button, exp_button);
            check("freq_set", freq_set, exp_freq);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int last_rise;
        int exp_seq [5];
        bit prev;
        exp_seq = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        key_start = 1'b0;
        key_mode  = 1'b0;
        model_reset();
        check_en  = 1'b1;

        // Reset, then idle
        repeat (5) step();
        check("reset_button", button, 0);
        check("reset_freq", freq_set, 3);
        rst_n     = 1'b1;
        last_freq = 2'b11;
        freq_hist.delete();
        pulses = 0;
        run(100);
        check("idle_pulses", pulses, 0);
        check("idle_freq_changes", freq_hist.size(), 0);

        // Clean start press
        pulses    = 0;
        key_start = 1'b1;
        k0        = cyc + 1;
        run(50);
        key_start = 1'b0;
        run(50);
        check("clean_pulse_count", pulses, 1);
        check("clean_pulse_latency", pulse_cyc - k0, 10);

        // Bounce rejection
        pulses    = 0;
        prev      = 1'b0;
        last_rise = 0;
        for (int t = 0; t < 40; t++) begin
            key_start = ((t / 3) % 2) == 0;
            if (key_start && !prev) last_rise = cyc + 1;
            prev = key_start;
            run(1);
        end
        check("bounce_no_pulse", pulses, 0);
        key_start = 1'b1;
        if (!prev) last_rise = cyc + 1;
        run(30);
        check("bounce_pulse_count", pulses, 1);
        check("bounce_pulse_latency", pulse_cyc - last_rise, 10);
        key_start = 1'b0;
        run(30);

        // Mode wrap from reset
        assert_reset();
        release_reset();
        for (int p = 0; p < 5; p++) begin
            key_mode = 1'b1;
            run(20);
            key_mode = 1'b0;
            run(20);
        end
        check("wrap_steps", freq_hist.size(), 5);
        for (int p = 0; p < 5; p++) begin
            if (p < freq_hist.size()) check("wrap_value", freq_hist[p], exp_seq[p]);
        end

        // Simultaneous presses
        pulses = 0;
        freq_hist.delete();
        key_start = 1'b1;
        key_mode  = 1'b1;
        run(30);
        check("simul_pulse", pulses, 1);
        check("simul_freq_steps", freq_hist.size(), 1);
        check("simul_same_cycle", freq_cyc - pulse_cyc, 0);
        key_start = 1'b0;
        key_mode  = 1'b0;
        run(30);

        // Reset in the middle of a mode press debounce
        assert_reset();
        release_reset();
        for (int p = 0; p < 2; p++) begin
            key_mode = 1'b1;
            run(20);
            key_mode = 1'b0;
            run(20);
        end
        check("pre_reset_freq", freq_set, 1);
        key_mode = 1'b1;
        run(8);
        assert_reset();
        release_reset();
        k0 = cyc + 1;
        run(30);
        check("post_reset_steps", freq_hist.size(), 1);
        if (freq_hist.size() > 0) check("post_reset_value", freq_hist[0], 0);
        check("post_reset_latency", freq_cyc - k0, 10);
        key_mode = 1'b0;
        run(30);

        // Randomized key activity with occasional resets
        for (int s = 0; s < 120; s++) begin
            key_start = 1'($urandom_range(0, 1));
            key_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                assert_reset();
                release_reset();
            end
            run(int'($urandom_range(1, 20)));
        end
        key_start = 1'b0;
        key_mode  = 1'b0;
        run(30);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
